state_predict_seq: RTL
======================

# state_predict_seq

Sequential, parametrised successor to the EKF prediction stage for the PMSM sensorless observer. It computes the predicted state (ialpha, ibeta, omega, theta) and the 4x4 Jacobian F / F-transpose for one sample period using a single time-shared Q-format multiplier behind a start/done handshake. It adds three behaviours: theta wrapping into [-pi, pi), sticky overflow reporting, and optional saturating accumulation. It sits between the sin/cos generator and the covariance-predict block.

## Interface
- N, 32, word width (signed Q format)
- Q, 18, fractional bits; SF = 2^Q
- TS_LS, 124, Ts/Ls in Q format
- RS_TS_LS, 183, Rs*Ts/Ls in Q format
- LAM_TS_LS, 25, Lambda*Ts/Ls in Q format
- T_Q, 2, Ts in Q format
- PI_Q, 823550, pi in Q format

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- start  in  1  request; sampled only in IDLE or DONE
- ialpha, ibeta, valpha, vbeta, omega, theta, stheta, ctheta  in  N each  signed Q inputs, latched on accept
- busy  out  1  high while computing
- done  out  1  one-cycle pulse, results valid
- ialphae, ibetae, omegae, thetae  out  N each  registered predicted state
- F, F_transpose  out  16N each  Jacobian; entry (r,c) at bits [(4r+c)*N +: N]
- ovf  out  1  overflow seen during the last run, registered with results

## Operation
- States: IDLE -> MUL (cnt 0..8) -> SUM -> DONE -> IDLE. start=1 in IDLE or DONE latches all inputs, clears the internal overflow accumulator, sets cnt=0 and enters MUL. start in MUL or SUM is ignored.
- MUL step k registers product p[k] = a*b:
  - k0 valpha*TS_LS
  - k1 ialpha*RS_TS_LS
  - k2 stheta*LAM_TS_LS
  - k3 omega*p2
  - k4 vbeta*TS_LS
  - k5 ibeta*RS_TS_LS
  - k6 ctheta*LAM_TS_LS
  - k7 omega*p6
  - k8 omega*T_Q
- Multiply rule: full 2N signed product, arithmetic shift right by Q (floor), keep the low N bits. Overflow when the discarded upper bits are not a sign extension of bit N-1; this ORs into the accumulator.
- SUM registers:
  - ialphae = ialpha + p0 - p1 + p3
  - ibetae = ibeta + p4 - p5 - p7
  - omegae = omega
  - thetae: s = theta + p8; if s >= PI_Q then s - 2*PI_Q; if s < -PI_Q then s + 2*PI_Q; otherwise s
- F entries: (0,0)=(1,1)=SF-RS_TS_LS, (0,2)=p2, (0,3)=p7, (1,2)=-p6, (1,3)=p3, (2,2)=SF, (3,2)=T_Q, (3,3)=SF, all others 0. F_transpose(r,c) = F(c,r).
- Outputs hold their values until the next SUM. ovf is updated only in SUM.

## Timing
- Accept edge E0. Products register at E1..E9. SUM registers outputs at E10. done=1 and busy=0 in the cycle after E10.
- busy=1 in the cycles following E0 through E9.
- Latency from start to done is 11 cycles. Back-to-back throughput is 1 result per 11 cycles, with start accepted in the DONE cycle.
- Reset (reset=0 at an edge): state IDLE; busy, done, ovf = 0; all state outputs, F and F_transpose = 0.
- Reset mid-run aborts the run: no done pulse, and outputs are cleared to 0.
- start and reset asserted at the same edge: reset wins.

## Configuration
- STATE_PREDICT_SAT_EN defined: each add/subtract in SUM is computed at N+2 bits and clamped to [-2^(N-1), 2^(N-1)-1]. Any clamp ORs into ovf. The theta wrap is applied after the unclamped sum and is never clamped.
- Undefined: sums wrap modulo 2^N, and ovf reflects multiplier overflow only.

## Test plan
- Reset: start a run, then drive reset=0 at cycle 5 for 2 cycles -> busy=0, done never pulses, all outputs 0, ovf=0.
- Latency/handshake: start at cycle 0, pulse start again at cycle 4 -> single done pulse at cycle 11, busy high in cycles 1-10, second start ignored. start in the DONE cycle -> next done at cycle 22.
- Zero speed: ialpha=262144, ibeta=0, vbeta=262144, valpha=0, omega=0, theta=1000 -> ialphae=261961, ibetae=124, thetae=1000, F(0,0)=261961, F(3,2)=2, ovf=0.
- Theta wrap: theta=823549, omega=26214400 -> p8=200, thetae=-823351. With theta=-823549, omega=-26214400 -> thetae=823351.
- Overflow (params TS_LS=1048576, RS_TS_LS=0): ialpha=0x7FFF0000, valpha=1048576, other inputs 0.
  - With STATE_PREDICT_SAT_EN: ialphae=0x7FFFFFFF, ovf=1.
  - Without: ialphae=0x803F0000, ovf=0.
- Multiplier overflow (same params): valpha=2^30 -> ovf=1 in both builds. The following run with valpha=0 -> ovf=0.

Source files
------------

// File: rtl/state_predict_seq_if.sv
// Handshake and data bundle for the sequential EKF state-prediction stage.
// The master side drives start and the sampled inputs; the slave side returns the predicted state, Jacobian and overflow flag.
interface state_predict_seq_if #(
    parameter int N = 32
);
    logic                  start;
    logic signed [N-1:0]   ialpha;
    logic signed [N-1:0]   ibeta;
    logic signed [N-1:0]   valpha;
    logic signed [N-1:0]   vbeta;
    logic signed [N-1:0]   omega;
    logic signed [N-1:0]   theta;
    logic signed [N-1:0]   stheta;
    logic signed [N-1:0]   ctheta;
    logic                  busy;
    logic                  done;
    logic signed [N-1:0]   ialphae;
    logic signed [N-1:0]   ibetae;
    logic signed [N-1:0]   omegae;
    logic signed [N-1:0]   thetae;
    logic [16*N-1:0]       F;
    logic [16*N-1:0]       F_transpose;
    logic                  ovf;

    modport master (
        output start, ialpha, ibeta, valpha, vbeta, omega, theta, stheta, ctheta,
        input  busy, done, ialphae, ibetae, omegae, thetae, F, F_transpose, ovf
    );

    modport slave (
        input  start, ialpha, ibeta, valpha, vbeta, omega, theta, stheta, ctheta,
        output busy, done, ialphae, ibetae, omegae, thetae, F, F_transpose, ovf
    );
endinterface

// File: rtl/state_predict_seq.sv
// EKF state prediction using one time-shared Q-format multiplier, with theta wrapping and a sticky overflow flag.
// Define STATE_PREDICT_SAT_EN to clamp the ialpha/ibeta sums to the N-bit range and report each clamp on ovf.
module state_predict_seq #(
    parameter int N         = 32,
    parameter int Q         = 18,
    parameter int TS_LS     = 124,
    parameter int RS_TS_LS  = 183,
    parameter int LAM_TS_LS = 25,
    parameter int T_Q       = 2,
    parameter int PI_Q      = 823550
) (
    input logic                clk,
    input logic                reset,
    state_predict_seq_if.slave bus
);

    localparam logic signed [N-1:0]   TS_W     = N'(TS_LS);
    localparam logic signed [N-1:0]   RS_W     = N'(RS_TS_LS);
    localparam logic signed [N-1:0]   LAM_W    = N'(LAM_TS_LS);
    localparam logic signed [N-1:0]   TQ_W     = N'(T_Q);
    localparam logic signed [N-1:0]   SF_W     = N'(1 << Q);
    localparam logic signed [N-1:0]   F_DIAG   = SF_W - RS_W;
    localparam logic signed [N+1:0]   PI_W     = (N+2)'(PI_Q);
    localparam logic signed [N+1:0]   TWO_PI_W = PI_W + PI_W;

    typedef enum logic [1:0] {IDLE, MUL, SUM, DONE} stateT;

    stateT               state;
    stateT               nextState;
    logic [3:0]          cnt;
    logic                accept;
    logic                ovfAcc;

    logic signed [N-1:0] ialphaR, ibetaR, valphaR, vbetaR;
    logic signed [N-1:0] omegaR, thetaR, sthetaR, cthetaR;
    logic signed [N-1:0] prod [0:8];

    logic signed [N-1:0] ialphaeR, ibetaeR, omegaeR, thetaeR;
    logic [16*N-1:0]     fR, ftR;
    logic                ovfR;

    logic signed [N-1:0]   mulA, mulB, mulRes;
    logic signed [2*N-1:0] fullProd, shifted;
    logic                  mulOvf;

    logic signed [N-1:0] ialphaeNext, ibetaeNext, thetaeNext;
    logic signed [N+1:0] thetaSum;
    logic                sumOvf;
    logic [16*N-1:0]     fNext, ftNext;

    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.start) nextState = MUL;
            MUL:     if (cnt == 4'd8) nextState = SUM;
            SUM:     nextState = DONE;
            DONE:    nextState = bus.start ? MUL : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Step k of the schedule selects operands; steps 3 and 7 reuse products registered earlier in the run.
    always_comb begin
        mulA = '0;
        mulB = '0;
        case (cnt)
            4'd0:    begin mulA = valphaR; mulB = TS_W;    end
            4'd1:    begin mulA = ialphaR; mulB = RS_W;    end
            4'd2:    begin mulA = sthetaR; mulB = LAM_W;   end
            4'd3:    begin mulA = omegaR;  mulB = prod[2]; end
            4'd4:    begin mulA = vbetaR;  mulB = TS_W;    end
            4'd5:    begin mulA = ibetaR;  mulB = RS_W;    end
            4'd6:    begin mulA = cthetaR; mulB = LAM_W;   end
            4'd7:    begin mulA = omegaR;  mulB = prod[6]; end
            4'd8:    begin mulA = omegaR;  mulB = TQ_W;    end
            default: ;
        endcase
        fullProd = (2*N)'(mulA) * (2*N)'(mulB);
        shifted  = fullProd >>> Q;
        mulRes   = shifted[N-1:0];
        mulOvf   = !((&shifted[2*N-1:N-1]) || !(|shifted[2*N-1:N-1]));
    end

`ifdef STATE_PREDICT_SAT_EN
    localparam logic signed [N+1:0] SAT_MAX = {3'b000, {(N-1){1'b1}}};
    localparam logic signed [N+1:0] SAT_MIN = {3'b111, {(N-1){1'b0}}};
    logic signed [N+1:0] iaWide, ibWide;
`endif

    // Theta wraps on the unclamped wide sum so the wrap is exact regardless of saturation.
    always_comb begin
        thetaSum = (N+2)'(thetaR) + (N+2)'(prod[8]);
        if (thetaSum >= PI_W) begin
            thetaeNext = N'(thetaSum - TWO_PI_W);
        end else if (thetaSum < -PI_W) begin
            thetaeNext = N'(thetaSum + TWO_PI_W);
        end else begin
            thetaeNext = N'(thetaSum);
        end
`ifdef STATE_PREDICT_SAT_EN
        sumOvf = 1'b0;
        iaWide = (N+2)'(ialphaR) + (N+2)'(prod[0]) - (N+2)'(prod[1]) + (N+2)'(prod[3]);
        ibWide = (N+2)'(ibetaR) + (N+2)'(prod[4]) - (N+2)'(prod[5]) - (N+2)'(prod[7]);
        if (iaWide > SAT_MAX) begin
            ialphaeNext = N'(SAT_MAX);
            sumOvf      = 1'b1;
        end else if (iaWide < SAT_MIN) begin
            ialphaeNext = N'(SAT_MIN);
            sumOvf      = 1'b1;
        end else begin
            ialphaeNext = N'(iaWide);
        end
        if (ibWide > SAT_MAX) begin
            ibetaeNext = N'(SAT_MAX);
            sumOvf     = 1'b1;
        end else if (ibWide < SAT_MIN) begin
            ibetaeNext = N'(SAT_MIN);
            sumOvf     = 1'b1;
        end else begin
            ibetaeNext = N'(ibWide);
        end
`else
        sumOvf      = 1'b0;
        ialphaeNext = ialphaR + prod[0] - prod[1] + prod[3];
        ibetaeNext  = ibetaR + prod[4] - prod[5] - prod[7];
`endif
    end

    always_comb begin
        fNext             = '0;
        fNext[0*N +: N]   = F_DIAG;
        fNext[2*N +: N]   = prod[2];
        fNext[3*N +: N]   = prod[7];
        fNext[5*N +: N]   = F_DIAG;
        fNext[6*N +: N]   = -prod[6];
        fNext[7*N +: N]   = prod[3];
        fNext[10*N +: N]  = SF_W;
        fNext[14*N +: N]  = TQ_W;
        fNext[15*N +: N]  = SF_W;
        ftNext = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ftNext[(4*r+c)*N +: N] = fNext[(4*c+r)*N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            ovfAcc   <= 1'b0;
            ialphaR  <= '0;
            ibetaR   <= '0;
            valphaR  <= '0;
            vbetaR   <= '0;
            omegaR   <= '0;
            thetaR   <= '0;
            sthetaR  <= '0;
            cthetaR  <= '0;
            for (int k = 0; k < 9; k++) prod[k] <= '0;
            ialphaeR <= '0;
            ibetaeR  <= '0;
            omegaeR  <= '0;
            thetaeR  <= '0;
            fR       <= '0;
            ftR      <= '0;
            ovfR     <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            ovfAcc  <= 1'b0;
            ialphaR <= bus.ialpha;
            ibetaR  <= bus.ibeta;
            valphaR <= bus.valpha;
            vbetaR  <= bus.vbeta;
            omegaR  <= bus.omega;
            thetaR  <= bus.theta;
            sthetaR <= bus.stheta;
            cthetaR <= bus.ctheta;
        end else if (state == MUL) begin
            prod[cnt] <= mulRes;
            ovfAcc    <= ovfAcc | mulOvf;
            cnt       <= cnt + 4'd1;
        end else if (state == SUM) begin
            ialphaeR <= ialphaeNext;
            ibetaeR  <= ibetaeNext;
            omegaeR  <= omegaR;
            thetaeR  <= thetaeNext;
            fR       <= fNext;
            ftR      <= ftNext;
            ovfR     <= ovfAcc | sumOvf;
        end
    end

    assign bus.busy        = (state == MUL) || (state == SUM);
    assign bus.done        = (state == DONE);
    assign bus.ialphae     = ialphaeR;
    assign bus.ibetae      = ibetaeR;
    assign bus.omegae      = omegaeR;
    assign bus.thetae      = thetaeR;
    assign bus.F           = fR;
    assign bus.F_transpose = ftR;
    assign bus.ovf         = ovfR;

endmodule
